// File: rtl/board_clock_stepper.sv
// board_clock_stepper: debounced push-button step source for the processor.
// Turns a raw active-low key into a one-cycle ProcEnable pulse for single-step,
// N-step burst or free-run execution, and exports the step count and status.
// Ports:
//   Clock, Resetn           board clock, asynchronous active-low reset
//   KeyStep                 raw push button, active-low, asynchronous
//   Mode[1:0]               00 single-step, 01 burst, 10 free-run, 11 hold
//   BurstLen[BURST_WIDTH]   pulses per burst, sampled at burst start
//   Divisor[DIV_WIDTH]      pulse period in cycles (0 and 1 = every cycle)
//   Halt                    synchronous stop request
//   ProcEnable              registered one-cycle step pulse
//   StepCount[15:0]         pulses issued since reset, wraps
//   Busy                    high while a burst or free-run is active
//   KeyLevel                debounced key level, 1 = pressed
module board_clock_stepper #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DIV_WIDTH       = 26,
  parameter int unsigned BURST_WIDTH     = 8
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   KeyStep,
  input  logic [1:0]             Mode,
  input  logic [BURST_WIDTH-1:0] BurstLen,
  input  logic [DIV_WIDTH-1:0]   Divisor,
  input  logic                   Halt,
  output logic                   ProcEnable,
  output logic [15:0]            StepCount,
  output logic                   Busy,
  output logic                   KeyLevel
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BURST = 2'b01,
    S_RUN   = 2'b10
  } state_e;

  logic                   sync1_q, sync2_q;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   key_level_q, key_level_d;
  logic                   key_prev_q;
  logic                   press;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0]   period;
  logic                   due;
  logic                   pulse_d;
  logic                   proc_en_q;
  logic [CNT_W-1:0]       step_cnt_q;
  logic                   busy_q;

  // Debounce: accept the synchronised level after DEBOUNCE_CYCLES disagreeing samples in a row
  always_comb begin
    db_cnt_d    = db_cnt_q;
    key_level_d = key_level_q;
    if (sync2_q == key_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_d    = '0;
      key_level_d = sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign press  = key_level_q & ~key_prev_q;
  assign period = (Divisor == '0) ? DIV_WIDTH'(1) : Divisor;
  // div_cnt counts down to the next pulse; zero means a pulse is due this edge
  assign due    = (div_cnt_q == '0);

  // Sequencer next-state: Halt beats everything, a completing burst beats a press
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    rem_d     = rem_q;
    pulse_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Halt && press) begin
          case (Mode)
            2'b00: pulse_d = 1'b1;
            2'b01: begin
              if (BurstLen != '0) begin
                rem_d     = BurstLen;
                div_cnt_d = '0;
                state_d   = S_BURST;
              end
            end
            2'b10: begin
              div_cnt_d = '0;
              state_d   = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_BURST: begin
        if (Halt || Mode != 2'b01) begin
          state_d = S_IDLE;
        end else if (due && rem_q == BURST_WIDTH'(1)) begin
          pulse_d = 1'b1;
          rem_d   = '0;
          state_d = S_IDLE;
        end else if (press) begin
          state_d = S_IDLE;
        end else if (due) begin
          pulse_d   = 1'b1;
          rem_d     = rem_q - BURST_WIDTH'(1);
          div_cnt_d = period - DIV_WIDTH'(1);
        end else begin
          div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
        end
      end
      S_RUN: begin
        if (Halt || Mode != 2'b10 || press) begin
          state_d = S_IDLE;
        end else if (due) begin
          pulse_d   = 1'b1;
          div_cnt_d = period - DIV_WIDTH'(1);
        end else begin
          div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      key_level_q <= 1'b0;
      key_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      rem_q       <= '0;
      proc_en_q   <= 1'b0;
      step_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= ~KeyStep;
      sync2_q     <= sync1_q;
      db_cnt_q    <= db_cnt_d;
      key_level_q <= key_level_d;
      key_prev_q  <= key_level_q;
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      rem_q       <= rem_d;
      proc_en_q   <= pulse_d;
      busy_q      <= (state_d != S_IDLE);
      if (pulse_d) begin
        step_cnt_q <= step_cnt_q + CNT_W'(1);
      end
    end
  end

  assign ProcEnable = proc_en_q;
  assign StepCount  = step_cnt_q;
  assign Busy       = busy_q;
  assign KeyLevel   = key_level_q;

endmodule

// File: tb/tb_board_clock_stepper.sv
// Testbench for board_clock_stepper: random key/mode/halt stimulus compared
// every cycle against a time-stamped behavioural model, plus directed scenarios.
module tb_board_clock_stepper;

  localparam int unsigned DB  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned BW  = 8;

  logic          Clock;
  logic          Resetn;
  logic          KeyStep;
  logic [1:0]    Mode;
  logic [BW-1:0] BurstLen;
  logic [DW-1:0] Divisor;
  logic          Halt;
  logic          ProcEnable;
  logic [15:0]   StepCount;
  logic          Busy;
  logic          KeyLevel;

  board_clock_stepper #(
    .DEBOUNCE_CYCLES(DB),
    .DIV_WIDTH      (DW),
    .BURST_WIDTH    (BW)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .KeyStep   (KeyStep),
    .Mode      (Mode),
    .BurstLen  (BurstLen),
    .Divisor   (Divisor),
    .Halt      (Halt),
    .ProcEnable(ProcEnable),
    .StepCount (StepCount),
    .Busy      (Busy),
    .KeyLevel  (KeyLevel)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw samples reach the debouncer two edges late; a level is
  // accepted once the last DB seen samples all disagree with it. Pulses are
  // scheduled by absolute cycle number.
  bit          raw_q[$];
  bit          seen_q[$];
  bit          m_lvl, m_lvl_old;
  int          m_act;            // 0 idle, 1 burst, 2 run
  int          m_left;
  longint      m_cyc, m_next;
  bit          m_en;
  bit [15:0]   m_cnt;
  int          m_total;
  bit          s_seen, s_press, s_due, s_agree, s_pulse;
  int          s_p;

  task automatic mdl_reset();
    raw_q.delete();
    raw_q.push_back(1'b0);
    raw_q.push_back(1'b0);
    seen_q.delete();
    m_lvl = 0; m_lvl_old = 0; m_act = 0; m_left = 0;
    m_next = 0; m_en = 0; m_cnt = 0; m_total = 0;
  endtask

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mdl_reset();
    end else begin
      m_cyc++;
      s_press   = m_lvl && !m_lvl_old;
      m_lvl_old = m_lvl;
      s_seen    = raw_q.pop_front();
      raw_q.push_back(!KeyStep);
      seen_q.push_back(s_seen);
      if (seen_q.size() > DB) void'(seen_q.pop_front());
      if (seen_q.size() == DB) begin
        s_agree = 0;
        foreach (seen_q[i]) if (seen_q[i] == m_lvl) s_agree = 1;
        if (!s_agree) m_lvl = s_seen;
      end
      s_pulse = 0;
      s_p     = (Divisor <= 1) ? 1 : int'(Divisor);
      if (m_act != 0) begin
        if (Halt || Mode != ((m_act == 1) ? 2'b01 : 2'b10)) begin
          m_act = 0;
        end else begin
          s_due = (m_cyc == m_next);
          if (m_act == 1 && s_due && m_left == 1) begin
            s_pulse = 1; m_act = 0;
          end else if (s_press) begin
            m_act = 0;
          end else if (s_due) begin
            s_pulse = 1;
            if (m_act == 1) m_left--;
            m_next = m_cyc + s_p;
          end
        end
      end else if (!Halt && s_press) begin
        case (Mode)
          2'b00: s_pulse = 1;
          2'b01: if (BurstLen != 0) begin m_act = 1; m_left = int'(BurstLen); m_next = m_cyc + 1; end
          2'b10: begin m_act = 2; m_next = m_cyc + 1; end
          default: ;
        endcase
      end
      m_en = s_pulse;
      if (s_pulse) begin m_cnt++; m_total++; end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("ProcEnable", 32'(ProcEnable), 32'(m_en));
      check("StepCount",  32'(StepCount),  32'(m_cnt));
      check("Busy",       32'(Busy),       32'(m_act != 0));
      check("KeyLevel",   32'(KeyLevel),   32'(m_lvl));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic press_key(input int hold);
    KeyStep = 1'b0;
    cycles(hold);
    KeyStep = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},   32'(ProcEnable), 32'd0);
    check({tag, "_cnt"},  32'(StepCount),  32'd0);
    check({tag, "_busy"}, 32'(Busy),       32'd0);
    check({tag, "_key"},  32'(KeyLevel),   32'd0);
  endtask

  bit [15:0] base;
  int        hold;

  initial begin
    Resetn = 1'b0; KeyStep = 1'b1; Mode = 2'b00;
    BurstLen = '0; Divisor = '0; Halt = 1'b0;
    #1 chk_en = 1'b1;
    cycles(3);
    check_all_zero("reset");
    Resetn = 1'b1;

    // Glitch shorter than the debounce window is rejected
    press_key(3);
    cycles(12);
    check("glitch_key", 32'(KeyLevel), 32'd0);
    check("glitch_cnt", 32'(StepCount), 32'd0);

    // Single-step, then again, then blocked by Halt
    press_key(20); cycles(12);
    check("single1", 32'(StepCount), 32'd1);
    press_key(20); cycles(12);
    check("single2", 32'(StepCount), 32'd2);
    Halt = 1'b1;
    press_key(20); cycles(12);
    check("single_halt", 32'(StepCount), 32'd2);
    Halt = 1'b0;

    // Random phase
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: Mode = 2'b00;
        4, 5, 6:    Mode = 2'b01;
        7, 8:       Mode = 2'b10;
        default:    Mode = 2'b11;
      endcase
      Divisor  = DW'($urandom_range(0, 4));
      BurstLen = BW'($urandom_range(0, 6));
      Halt     = ($urandom_range(0, 9) == 0);
      hold     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(7, 25);
      press_key(hold);
      hold = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 99) < 3) Mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 99) < 5) Divisor = DW'($urandom_range(0, 4));
        if ($urandom_range(0, 99) < 3) Halt = ~Halt;
        cycles(1);
      end
    end

    // Settle to idle
    KeyStep = 1'b1; Halt = 1'b1; Mode = 2'b11;
    cycles(15);
    Halt = 1'b0;

    // Burst of 5 with period 3, then an empty burst
    Mode = 2'b01; BurstLen = 8'd5; Divisor = 8'd3;
    base = m_cnt;
    press_key(10); cycles(30);
    check("burst5", 32'(StepCount), 32'(base + 16'd5));
    check("burst5_busy", 32'(Busy), 32'd0);
    BurstLen = 8'd0;
    base = m_cnt;
    press_key(10); cycles(30);
    check("burst0", 32'(StepCount), 32'(base));

    // Free-run stopped by Halt
    Mode = 2'b10; Divisor = 8'd0;
    press_key(10); cycles(5);
    check("run_busy", 32'(Busy), 32'd1);
    Halt = 1'b1;
    cycles(1);
    check("halt_en", 32'(ProcEnable), 32'd0);
    check("halt_busy", 32'(Busy), 32'd0);
    Halt = 1'b0;
    cycles(10);

    // Mid-burst mode change aborts
    Mode = 2'b01; BurstLen = 8'd8; Divisor = 8'd2;
    press_key(10); cycles(2);
    Mode = 2'b00;
    cycles(1);
    check("modechg_busy", 32'(Busy), 32'd0);
    base = m_cnt;
    cycles(20);
    check("modechg_cnt", 32'(StepCount), 32'(base));

    // Reset mid-burst
    Mode = 2'b01; BurstLen = 8'd6; Divisor = 8'd4;
    press_key(10); cycles(3);
    #2 Resetn = 1'b0;
    #1 check_all_zero("midreset");
    cycles(3);
    Resetn = 1'b1;
    cycles(30);
    check("post_reset_cnt", 32'(StepCount), 32'd0);

    // Wrap after 65536 free-run pulses
    Mode = 2'b10; Divisor = 8'd0;
    press_key(10);
    for (int i = 0; i < 70000 && m_total < 65536; i++) cycles(1);
    if (m_total < 65536) check("wrap_timeout", 32'(m_total), 32'd65536);
    else check("wrap_cnt", 32'(StepCount), 32'h0000);
    press_key(10); cycles(10);
    check("wrap_stop", 32'(Busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/board_clock_stepper.md
# board_clock_stepper

Parametrised manual/automatic clock-enable generator for the DE2 board top level. It replaces driving the processor clock directly from a push button with a debounced, synchronised step source on the 50 MHz board clock. It emits a one-cycle `ProcEnable` pulse for single-step, N-step burst or free-run execution of `processador_multiciclo`. It sits between `KEY`/`SW` and the processor, and exports step count and status for the HEX/LED displays.

## Interface
- `DEBOUNCE_CYCLES`, 50000: consecutive stable synchronised samples required to accept a new key level.
- `DIV_WIDTH`, 26: width of the free-run/burst period input.
- `BURST_WIDTH`, 8: width of the burst length input.
- `Clock`  in  1  board clock; all state on rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `KeyStep`  in  1  raw push button, active-low (0 = pressed), asynchronous to `Clock`.
- `Mode`  in  2  00 single-step, 01 burst, 10 free-run, 11 hold.
- `BurstLen`  in  BURST_WIDTH  pulses per burst; sampled at burst start.
- `Divisor`  in  DIV_WIDTH  pulse period in `Clock` cycles; 0 and 1 both mean every cycle.
- `Halt`  in  1  synchronous stop request, e.g. processor `Done`.
- `ProcEnable`  out  1  registered one-cycle step pulse.
- `StepCount`  out  16  pulses issued since reset, wraps.
- `Busy`  out  1  high in BURST or RUN.
- `KeyLevel`  out  1  debounced key, 1 = pressed.

## Operation
- Synchroniser: 2 flip-flops on `~KeyStep`, reset to 0 (released).
- Debounce: a counter clears whenever the synchronised value equals `KeyLevel`. Otherwise it increments. When it reaches `DEBOUNCE_CYCLES`, `KeyLevel` takes the synchronised value and the counter clears.
- Press event: `KeyLevel` registered 0→1. Release generates nothing.
- States are IDLE, BURST and RUN. Period counter `div_cnt` (DIV_WIDTH). Remaining counter `rem` (BURST_WIDTH).
- IDLE:
  - Mode 00 + press: `ProcEnable` pulse next cycle; stay IDLE.
  - Mode 01 + press: if `BurstLen`≠0, load `rem`=`BurstLen` and go to BURST. If 0, nothing happens.
  - Mode 10 + press: go to RUN.
  - Mode 11: presses are ignored.
- BURST:
  - First pulse one cycle after entry, then one every P = max(`Divisor`,1) cycles.
  - `rem` decrements on each pulse. The state returns to IDLE on the edge that issues the pulse taking `rem` to 0.
  - A press aborts to IDLE with no further pulses.
- RUN:
  - First pulse one cycle after entry, then every P cycles.
  - A press returns to IDLE.
- `Divisor` is re-read at each period reload. A change takes effect at the next pulse.
- Abort conditions: a `Mode` change or `Halt`=1 while in BURST/RUN → IDLE on the next edge. No pulse is issued in any cycle where `Halt` was sampled high.
- `Halt`=1 in IDLE also blocks single-step and the start of BURST/RUN.
- `StepCount` increments on the same edge that raises `ProcEnable`. 0xFFFF→0x0000.
- Simultaneous events: a press in the same cycle a burst completes is ignored. A `Halt` in the same cycle as a press takes priority, so no action is taken.

## Timing
- Reset (async, immediate): `ProcEnable`=0, `StepCount`=0, `Busy`=0, `KeyLevel`=0, state IDLE, all counters 0.
- Reset mid-burst aborts with no residual pulse after release.
- Key latency: a raw change to `KeyLevel` takes 2 + `DEBOUNCE_CYCLES` cycles when stable. Any shorter glitch is rejected.
- Single-step: `ProcEnable` high exactly 1 cycle, on the cycle after `KeyLevel` rises.
- Burst/run: `Busy` rises on the cycle after the press. The first pulse follows 1 cycle later, with consecutive pulses P cycles apart.
- In burst, `Busy` falls on the same edge as the last pulse.
- `ProcEnable` is never high for 2 consecutive cycles unless P=1.

## Test plan
- Glitch rejection, `DEBOUNCE_CYCLES`=4: `KeyStep` low for 3 cycles then high → `KeyLevel` stays 0, no `ProcEnable`, `StepCount`=0.
- Single-step, Mode=00: key held low 20 cycles → exactly one pulse, `StepCount`=1. Release then press again → `StepCount`=2. Same with `Halt`=1 → `StepCount` unchanged.
- Burst, Mode=01, `BurstLen`=5, `Divisor`=3 → 5 pulses spaced 3 cycles, `Busy` high from press+1 to the last pulse, `StepCount`=5. With `BurstLen`=0 → no pulses and `Busy` stays 0.
- Free-run, Mode=10, `Divisor`=0 → a pulse every cycle after start. Second press stops. Restart, then `Halt`=1 → no pulse that cycle and state IDLE next edge.
- Wrap: free-run with P=1 for 65536 pulses → `StepCount`=0x0000. Mid-burst `Mode` change → IDLE with no further pulses.
- Reset: `Resetn` low mid-burst → all outputs 0 immediately. After release, no pulse without a fresh press.
